// File: rtl/usart_ctrl_fifo.sv
// Full-duplex UART with TX/RX FIFOs, programmable baud divisor, status byte and sticky errors.
// Optional registered interrupt output enabled by defining USART_IRQ_EN (irq tied 0 otherwise).
module usart_ctrl_fifo #(
  parameter int CLK_DIV_DEFAULT = 138,
  parameter int DATA_BITS       = 8,
  parameter int TX_DEPTH        = 4,
  parameter int RX_DEPTH        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       write,
  input  logic [2:0] cmd_in,
  input  logic [7:0] data_in,
  input  logic       read,
  output logic [7:0] data_out,
  output logic [7:0] status,
  input  logic       rx_pin,
  output logic       tx_pin,
  output logic       irq
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic cmd_ctrl, cmd_data, cmd_div_lo, cmd_div_hi;
  assign cmd_ctrl   = write && (cmd_in == 3'd1);
  assign cmd_data   = write && (cmd_in == 3'd2);
  assign cmd_div_lo = write && (cmd_in == 3'd3);
  assign cmd_div_hi = write && (cmd_in == 3'd4);

  logic [3:0]  ctrl_q;
  logic [15:0] div_q;
  logic [15:0] div_eff;
  assign div_eff = (div_q < 16'd2) ? 16'd2 : div_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= 4'd0;
      div_q  <= 16'(CLK_DIV_DEFAULT);
    end else begin
      if (cmd_ctrl)   ctrl_q      <= data_in[3:0];
      if (cmd_div_lo) div_q[7:0]  <= data_in;
      if (cmd_div_hi) div_q[15:8] <= data_in;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [TX_AW:0]       tx_wr_q, tx_rd_q;
  logic                 tx_fifo_empty, tx_fifo_full, tx_push, tx_pop;

  assign tx_fifo_empty = (tx_wr_q == tx_rd_q);
  assign tx_fifo_full  = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                         (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);
  assign tx_push       = cmd_data && !tx_fifo_full;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[TX_AW-1:0]] <= data_in[DATA_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
    end
  end

  // ---------------- TX baud counter and FSM ----------------
  logic [15:0]          tx_cnt_q;
  logic                 tx_tick;
  logic [1:0]           tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic                 tx_pin_q, tx_pin_d;

  // The counter free-runs so every bit boundary lands on a tick; >= guards a divisor shrink.
  assign tx_tick = (tx_cnt_q >= (div_eff - 16'd1));

  always_ff @(posedge clk) begin
    if (reset || cmd_div_lo || cmd_div_hi) tx_cnt_q <= 16'd0;
    else if (tx_tick)                      tx_cnt_q <= 16'd0;
    else                                   tx_cnt_q <= tx_cnt_q + 16'd1;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_pin_d   = tx_pin_q;
    tx_pop     = 1'b0;
    if (tx_tick) begin
      case (tx_state_q)
        TX_IDLE, TX_STOP: begin
          if (ctrl_q[0] && !tx_fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_mem[tx_rd_q[TX_AW-1:0]];
            tx_pin_d   = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tx_pin_d   = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end
        TX_START: begin
          tx_pin_d   = tx_shift_q[0];
          tx_bit_d   = 4'd0;
          tx_state_d = TX_DATA;
        end
        TX_DATA: begin
          if (tx_bit_q == LAST_BIT) begin
            tx_pin_d   = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_shift_d = tx_shift_q >> 1;
            tx_pin_d   = tx_shift_q[1];
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_bit_q   <= 4'd0;
      tx_pin_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_pin_q   <= tx_pin_d;
    end
  end

  assign tx_pin = tx_pin_q;

  // ---------------- RX synchroniser and FSM ----------------
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]           rx_state_q, rx_state_d;
  logic [15:0]          rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_sample, rx_push_req, frame_err_set;

  assign rx_sample = (rx_cnt_q == 16'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx_pin;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_push_req   = 1'b0;
    frame_err_set = 1'b0;
    if (!ctrl_q[1]) begin
      rx_state_d = RX_IDLE;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_state_d = RX_START;
            rx_cnt_d   = (div_eff >> 1) - 16'd1;
          end
        end
        RX_START: begin
          if (rx_sample) begin
            rx_cnt_d = div_eff - 16'd1;
            if (rx_s2_q) begin
              rx_state_d = RX_IDLE;
            end else begin
              rx_state_d = RX_DATA;
              rx_bit_d   = 4'd0;
            end
          end else begin
            rx_cnt_d = rx_cnt_q - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_sample) begin
            rx_cnt_d   = div_eff - 16'd1;
            rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
            else                      rx_bit_d   = rx_bit_q + 4'd1;
          end else begin
            rx_cnt_d = rx_cnt_q - 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_sample) begin
            rx_state_d = RX_IDLE;
            if (rx_s2_q) rx_push_req   = 1'b1;
            else         frame_err_set = 1'b1;
          end else begin
            rx_cnt_d = rx_cnt_q - 16'd1;
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [RX_AW:0]       rx_wr_q, rx_rd_q;
  logic                 rx_fifo_empty, rx_fifo_full, rx_pop, rx_push, overrun_set;
  logic [7:0]           head_ext;

  assign rx_fifo_empty = (rx_wr_q == rx_rd_q);
  assign rx_fifo_full  = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                         (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);
  assign rx_pop        = read && !rx_fifo_empty;
  // A same-cycle pop frees the head slot, which is exactly the slot the write pointer targets.
  assign rx_push       = rx_push_req && (!rx_fifo_full || rx_pop);
  assign overrun_set   = rx_push_req && rx_fifo_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q[RX_AW-1:0]] <= rx_shift_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_q <= '0;
      rx_rd_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
    end
  end

  always_comb begin
    head_ext = 8'd0;
    if (!rx_fifo_empty) head_ext[DATA_BITS-1:0] = rx_mem[rx_rd_q[RX_AW-1:0]];
  end

  assign data_out = head_ext;

  // ---------------- sticky flags and status ----------------
  logic rx_overrun_q, frame_err_q, tx_overflow_q;
  logic tx_busy, tx_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_overrun_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      if (cmd_ctrl && data_in[7]) begin
        rx_overrun_q  <= 1'b0;
        frame_err_q   <= 1'b0;
        tx_overflow_q <= 1'b0;
      end
      // A new error in the clearing cycle wins so it is never lost.
      if (overrun_set)               rx_overrun_q  <= 1'b1;
      if (frame_err_set)             frame_err_q   <= 1'b1;
      if (cmd_data && tx_fifo_full)  tx_overflow_q <= 1'b1;
    end
  end

  assign tx_busy  = (tx_state_q != TX_IDLE);
  assign tx_empty = tx_fifo_empty && !tx_busy;

  assign status = {tx_busy, tx_overflow_q, frame_err_q, rx_overrun_q,
                   tx_empty, tx_fifo_full, rx_fifo_full, !rx_fifo_empty};

`ifdef USART_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= (ctrl_q[3] && !rx_fifo_empty) || (ctrl_q[2] && tx_empty) ||
                        (ctrl_q[3] && (rx_overrun_q || frame_err_q));
  end
  assign irq = irq_q;
`else
  logic unused_irq_ctrl;
  assign unused_irq_ctrl = ^ctrl_q[3:2];
  assign irq = 1'b0;
`endif

endmodule
